// File: rtl/ysyx_25020047_ifu_pkg.sv
// ysyx_25020047_ifu_pkg
//   Shared definitions for the instruction fetch unit: FSM state encoding,
//   the word returned on a faulting fetch, and the default watchdog limit.
package ysyx_25020047_ifu_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StValid = 3'd3,
        StDrain = 3'd4
    } ifu_state_e;

    localparam logic [31:0] INST_FAULT_WORD        = 32'h0000_0000;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/ysyx_25020047_ifu_wdt.sv
// ysyx_25020047_ifu_wdt
//   Response watchdog for the fetch unit. The count clears when the fetch
//   enters WAIT and advances on every WAIT cycle; o_expired flags the cycle in
//   which the count reaches TIMEOUT_CYCLES-1.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_start       fetch enters WAIT at the next edge (clears the count)
//   i_active      fetch is currently in WAIT
//   o_expired     limit reached in this WAIT cycle
module ysyx_25020047_ifu_wdt
    import ysyx_25020047_ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_active,
    output logic o_expired
);

    logic [15:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 16'd0;
        end else if (i_start) begin
            r_count <= 16'd0;
        end else if (i_active) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = i_active && (r_count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ysyx_25020047_ifu.sv
// ysyx_25020047_ifu
//   Instruction fetch unit. Issues one outstanding read per fetch at the PC
//   sampled when leaving IDLE, holds the returned word (with PC and fault flag)
//   until decode accepts it, and handles misaligned PCs, bus errors and flushes.
//   Optional response watchdog: define YSYX_25020047_IFU_TIMEOUT_EN.
// Ports:
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_pc, i_fetch_en, i_flush           fetch control from the PC register
//   o_req_valid, o_req_addr, i_req_ready             memory request channel
//   i_rsp_valid, i_rsp_data, i_rsp_err               memory response channel
//   o_inst_valid, o_inst, o_inst_pc, o_fault, i_inst_ready  decode interface
module ysyx_25020047_ifu
    import ysyx_25020047_ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_fetch_en,
    input  logic        i_flush,
    output logic        o_req_valid,
    output logic [31:0] o_req_addr,
    input  logic        i_req_ready,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    input  logic        i_rsp_err,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    output logic        o_fault
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    ifu_state_e  r_state;
    logic [31:0] r_req_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_fault;
    logic        w_timeout;
    logic        w_orphan;

`ifdef YSYX_25020047_IFU_TIMEOUT_EN
    // Set when the watchdog gave up on a request that memory still owes us.
    logic r_orphan;
    logic w_wdt_start;
    logic w_wdt_active;

    assign w_wdt_start  = (r_state == StReq) && i_req_ready && !i_flush;
    assign w_wdt_active = (r_state == StWait);
    assign w_orphan     = r_orphan;

    ysyx_25020047_ifu_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_wdt_start),
        .i_active (w_wdt_active),
        .o_expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
    assign w_orphan  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_req_addr <= 32'd0;
            r_inst     <= 32'd0;
            r_inst_pc  <= 32'd0;
            r_fault    <= 1'b0;
`ifdef YSYX_25020047_IFU_TIMEOUT_EN
            r_orphan   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_fetch_en && !i_flush && !w_orphan) begin
                        r_req_addr <= {i_pc[31:2], 2'b00};
                        r_inst_pc  <= i_pc;
                        if (i_pc[1:0] != 2'b00) begin
                            // Misaligned: report the fault without touching the bus.
                            r_state <= StValid;
                            r_fault <= 1'b1;
                            r_inst  <= INST_FAULT_WORD;
                        end else begin
                            r_state <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (i_req_ready) begin
                        // An accepted request owes a response; flush must swallow it.
                        r_state <= i_flush ? StDrain : StWait;
                    end else if (i_flush) begin
                        r_state <= StIdle;
                    end
                end
                StWait: begin
                    if (i_rsp_valid) begin
                        if (i_flush) begin
                            r_state <= StIdle;
                        end else begin
                            r_state <= StValid;
                            r_fault <= i_rsp_err;
                            r_inst  <= i_rsp_err ? INST_FAULT_WORD : i_rsp_data;
                        end
                    end else if (i_flush) begin
                        r_state <= StDrain;
                    end else if (w_timeout) begin
                        r_state <= StValid;
                        r_fault <= 1'b1;
                        r_inst  <= INST_FAULT_WORD;
                    end
                end
                StValid: begin
                    if (i_flush || i_inst_ready) begin
                        r_state <= StIdle;
                    end
                end
                StDrain: begin
                    if (i_rsp_valid) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
`ifdef YSYX_25020047_IFU_TIMEOUT_EN
            if (r_orphan && i_rsp_valid) begin
                r_orphan <= 1'b0;
            end else if (r_state == StWait && w_timeout && !i_rsp_valid && !i_flush) begin
                r_orphan <= 1'b1;
            end
`endif
        end
    end

    assign o_req_valid  = (r_state == StReq);
    assign o_req_addr   = r_req_addr;
    assign o_inst_valid = (r_state == StValid);
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_fault      = r_fault;

endmodule
